// File: rtl/hci_core_req_buffer_if.sv
// hci_core_intf: HCI core handshake bundle (request, response, ECC handshake).
// The byte-enable width is DW/BW, where BW is the byte size in bits.
interface hci_core_intf #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32,
  parameter int unsigned BW = 8,
  parameter int unsigned UW = 1,
  parameter int unsigned IW = 8,
  parameter int unsigned EW = 1
);
  localparam int unsigned BEW = DW / BW;

  logic           req;
  logic           gnt;
  logic [AW-1:0]  add;
  logic           wen;
  logic [BEW-1:0] be;
  logic [DW-1:0]  data;
  logic [UW-1:0]  user;
  logic [IW-1:0]  id;
  logic [EW-1:0]  ecc;
  logic           ereq;
  logic           egnt;
  logic [DW-1:0]  r_data;
  logic           r_valid;
  logic           r_ready;
  logic [UW-1:0]  r_user;
  logic [IW-1:0]  r_id;
  logic [EW-1:0]  r_ecc;
  logic           r_evalid;
  logic           r_eready;

  modport initiator (
    output req, add, wen, be, data, user, id, ecc, ereq, r_ready, r_eready,
    input  gnt, egnt, r_data, r_valid, r_user, r_id, r_ecc, r_evalid
  );

  modport target (
    input  req, add, wen, be, data, user, id, ecc, ereq, r_ready, r_eready,
    output gnt, egnt, r_data, r_valid, r_user, r_id, r_ecc, r_evalid
  );
endinterface

// File: rtl/hci_core_req_buffer.sv
// hci_core_req_buffer: per-channel request FIFO, read-credit counter and
// response FIFO placed in front of one HCI core mux input.
// Optional feature macro: HCI_CORE_REQ_BUFFER_BYPASS_EN (combinational
// request pass-through when the request FIFO is empty).
module hci_core_req_buffer #(
  parameter int unsigned REQ_DEPTH = 4,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  hci_core_intf.target                 tgt,
  hci_core_intf.initiator              init,
  output logic [$clog2(REQ_DEPTH):0]   req_count_o,
  output logic [$clog2(MAX_OUTST):0]   outst_count_o
);
  localparam int unsigned DW      = $bits(tgt.data);
  localparam int unsigned AW      = $bits(tgt.add);
  localparam int unsigned BEW     = $bits(tgt.be);
  localparam int unsigned UW      = $bits(tgt.user);
  localparam int unsigned IW      = $bits(tgt.id);
  localparam int unsigned EW      = $bits(tgt.ecc);
  localparam int unsigned REQ_W   = AW + 1 + BEW + DW + UW + IW + EW;
  localparam int unsigned RSP_W   = DW + UW + IW + EW;
  localparam int unsigned WEN_BIT = REQ_W - AW - 1;
  localparam int unsigned RP_W    = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int unsigned SP_W    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned RC_W    = $clog2(REQ_DEPTH) + 1;
  localparam int unsigned OC_W    = $clog2(MAX_OUTST) + 1;

  localparam logic [RP_W-1:0] REQ_LAST  = RP_W'(REQ_DEPTH - 1);
  localparam logic [SP_W-1:0] RSP_LAST  = SP_W'(MAX_OUTST - 1);
  localparam logic [RC_W-1:0] REQ_FULLC = RC_W'(REQ_DEPTH);
  localparam logic [OC_W-1:0] OUTST_MAX = OC_W'(MAX_OUTST);

  // ---------------------------------------------------------------------
  // Request FIFO state
  // ---------------------------------------------------------------------
  logic [REQ_W-1:0] req_mem [REQ_DEPTH];
  logic [RP_W-1:0]  req_wptr_reg;
  logic [RP_W-1:0]  req_rptr_reg;
  logic [RC_W-1:0]  req_count_reg;

  // Response FIFO state (sized to the credit limit so it can never overflow)
  logic [RSP_W-1:0] rsp_mem [MAX_OUTST];
  logic [SP_W-1:0]  rsp_wptr_reg;
  logic [SP_W-1:0]  rsp_rptr_reg;
  logic [OC_W-1:0]  rsp_count_reg;

  logic [OC_W-1:0]  outst_count_reg;

  logic             req_full;
  logic             req_empty;
  logic             rsp_full;
  logic             rsp_empty;
  logic             credits_exhausted;
  logic [REQ_W-1:0] tgt_pkt;
  logic [REQ_W-1:0] head_pkt;
  logic [REQ_W-1:0] out_pkt;
  logic             out_valid;
  logic             bypass;
  logic             req_push;
  logic             req_pop;
  logic             read_issue;
  logic             rsp_push;
  logic             rsp_pop;

  assign req_full          = (req_count_reg == REQ_FULLC);
  assign req_empty         = (req_count_reg == '0);
  assign rsp_full          = (rsp_count_reg == OUTST_MAX);
  assign rsp_empty         = (rsp_count_reg == '0);
  assign credits_exhausted = (outst_count_reg == OUTST_MAX);

  assign tgt_pkt  = {tgt.add, tgt.wen, tgt.be, tgt.data, tgt.user, tgt.id, tgt.ecc};
  assign head_pkt = req_mem[req_rptr_reg];

`ifdef HCI_CORE_REQ_BUFFER_BYPASS_EN
  // Pass-through only when nothing is queued ahead and a read would have credit.
  assign bypass = req_empty & rst_ni & ~clear_i & tgt.req &
                  ~(tgt.wen & credits_exhausted);
`else
  assign bypass = 1'b0;
`endif

  // Select what the mux input sees: queued head, bypassed request, or zeros.
  always_comb begin
    out_pkt   = '0;
    out_valid = 1'b0;
    if (!req_empty) begin
      out_pkt   = head_pkt;
      out_valid = ~(head_pkt[WEN_BIT] & credits_exhausted);
    end else if (bypass) begin
      out_pkt   = tgt_pkt;
      out_valid = 1'b1;
    end
  end

  assign {init.add, init.wen, init.be, init.data, init.user, init.id, init.ecc} = out_pkt;
  assign init.req  = out_valid;
  assign init.ereq = out_valid;

  // gnt looks only at registered occupancy, never at init.gnt
  assign tgt.gnt  = ~req_full;
  assign tgt.egnt = ~req_full;

  // A bypassed request accepted downstream in the same cycle is never stored.
  assign req_push   = tgt.req & ~req_full & ~(bypass & init.gnt);
  assign req_pop    = out_valid & init.gnt & ~bypass;
  assign read_issue = out_valid & init.gnt & out_pkt[WEN_BIT];
  assign rsp_pop    = ~rsp_empty & tgt.r_ready;
  // Responses with no outstanding read (e.g. after a clear) are discarded.
  assign rsp_push   = init.r_valid & (outst_count_reg != '0) & ~rsp_full;

  // Request storage write; no reset so it can map onto distributed RAM.
  always_ff @(posedge clk_i) begin
    if (req_push) req_mem[req_wptr_reg] <= tgt_pkt;
  end

  // Request FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      req_wptr_reg  <= '0;
      req_rptr_reg  <= '0;
      req_count_reg <= '0;
    end else begin
      if (req_push) req_wptr_reg <= (req_wptr_reg == REQ_LAST) ? '0 : req_wptr_reg + 1'b1;
      if (req_pop)  req_rptr_reg <= (req_rptr_reg == REQ_LAST) ? '0 : req_rptr_reg + 1'b1;
      if (req_push && !req_pop)      req_count_reg <= req_count_reg + 1'b1;
      else if (req_pop && !req_push) req_count_reg <= req_count_reg - 1'b1;
    end
  end

  // Read credit counter: +1 per issued read, -1 per consumed response.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      outst_count_reg <= '0;
    end else if (read_issue && !rsp_pop) begin
      outst_count_reg <= outst_count_reg + 1'b1;
    end else if (rsp_pop && !read_issue) begin
      outst_count_reg <= outst_count_reg - 1'b1;
    end
  end

  // Response storage write.
  always_ff @(posedge clk_i) begin
    if (rsp_push) rsp_mem[rsp_wptr_reg] <= {init.r_data, init.r_user, init.r_id, init.r_ecc};
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      rsp_wptr_reg  <= '0;
      rsp_rptr_reg  <= '0;
      rsp_count_reg <= '0;
    end else begin
      if (rsp_push) rsp_wptr_reg <= (rsp_wptr_reg == RSP_LAST) ? '0 : rsp_wptr_reg + 1'b1;
      if (rsp_pop)  rsp_rptr_reg <= (rsp_rptr_reg == RSP_LAST) ? '0 : rsp_rptr_reg + 1'b1;
      if (rsp_push && !rsp_pop)      rsp_count_reg <= rsp_count_reg + 1'b1;
      else if (rsp_pop && !rsp_push) rsp_count_reg <= rsp_count_reg - 1'b1;
    end
  end

  assign {tgt.r_data, tgt.r_user, tgt.r_id, tgt.r_ecc} =
         rsp_empty ? '0 : rsp_mem[rsp_rptr_reg];
  assign tgt.r_valid   = ~rsp_empty;
  assign tgt.r_evalid  = 1'b0;
  assign init.r_ready  = 1'b1;
  assign init.r_eready = 1'b1;

  assign req_count_o   = req_count_reg;
  assign outst_count_o = outst_count_reg;

  // ECC handshake inputs are not used by this buffer.
  logic unused_ecc;
  assign unused_ecc = ^{tgt.ereq, tgt.r_eready, init.egnt, init.r_evalid};

`ifndef SYNTHESIS
  // Downstream must not return more responses than reads issued.
  assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
    !(init.r_valid && (outst_count_reg != '0) && rsp_full));
  // Both sides of the buffer must use the same field widths.
  assert property (@(posedge clk_i)
    ($bits(init.data) == DW) && ($bits(init.add) == AW) && ($bits(init.be) == BEW) &&
    ($bits(init.user) == UW) && ($bits(init.id) == IW) && ($bits(init.ecc) == EW));
`endif
endmodule
